// File: rtl/prbs_checker.sv
// prbs_checker
// Receive-side PRBS checker. It self-seeds an internal LFSR from the incoming
// words, confirms lock over LockWords clean words, and then counts bit errors
// and checked words for BER measurement.
//
// Sequence definition: s[n] = s[n-Length] ^ s[n-Tap]. Each word carries
// OutBits consecutive sequence bits, LSB first (bit 0 is the oldest bit).
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high
//   start      level; 1 = run the checker, 0 = return to IDLE
//   valid      data_in carries a word this cycle
//   data_in    received word (OutBits)
//   data_inv   invert data_in before use
//   clear_cnt  synchronous clear of all counters (FSM unaffected)
//   state      IDLE=0, SEED=1, VERIFY=2, LOCKED=3
//   locked     state == LOCKED
//   err_word   one-cycle pulse: the checked word had at least one bit error
//   err_bits   saturating count of bit errors seen while LOCKED
//   words      saturating count of words checked while LOCKED
//   loss_cnt   saturating count of LOCKED->SEED transitions
//   err_mask   XOR mask of the first errored word (capture build only)
//   err_index  value of words at the first errored word (capture build only)
//
// Optional feature: define PRBS_CHECKER_ERR_CAPTURE_EN to build the
// first-error capture registers; otherwise err_mask/err_index are tied to 0.
module prbs_checker #(
  parameter int Length    = 31,
  parameter int OutBits   = 16,
  parameter int CntWidth  = 32,
  parameter int LockWords = 8,
  parameter int LossWords = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                valid,
  input  logic [OutBits-1:0]  data_in,
  input  logic                data_inv,
  input  logic                clear_cnt,
  output logic [1:0]          state,
  output logic                locked,
  output logic                err_word,
  output logic [CntWidth-1:0] err_bits,
  output logic [CntWidth-1:0] words,
  output logic [7:0]          loss_cnt,
  output logic [OutBits-1:0]  err_mask,
  output logic [CntWidth-1:0] err_index
);

  // Feedback tap for x^Length + x^Tap + 1 (maximal-length trinomials).
  function automatic int tap_of(input int len);
    case (len)
      7:       return 6;
      9:       return 5;
      10:      return 7;
      11:      return 9;
      15:      return 14;
      17:      return 14;
      20:      return 17;
      23:      return 18;
      31:      return 28;
      default: return len - 1;
    endcase
  endfunction

  localparam int Tap       = tap_of(Length);
  localparam int SeedWords = (Length + OutBits - 1) / OutBits;
  localparam int PopW      = $clog2(OutBits + 1);
  localparam int SumW      = CntWidth + PopW;
  localparam int SeedCntW  = $clog2(SeedWords + 1);
  localparam int GoodW     = $clog2(LockWords + 1);
  localparam int BadW      = $clog2(LossWords + 1);
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // lfsr[Length-1] is the newest bit; advancing by one word leaves the
  // generated word in the top OutBits positions, bit 0 lowest.
  function automatic logic [Length-1:0] lfsr_adv(input logic [Length-1:0] st);
    logic [Length-1:0] s;
    logic              b;
    s = st;
    for (int i = 0; i < OutBits; i++) begin
      b = s[0] ^ s[Length-Tap];
      s = {b, s[Length-1:1]};
    end
    return s;
  endfunction

  function automatic logic [PopW-1:0] popcount(input logic [OutBits-1:0] v);
    logic [PopW-1:0] n;
    n = '0;
    for (int i = 0; i < OutBits; i++) n = n + PopW'(v[i]);
    return n;
  endfunction

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                  input logic [PopW-1:0]     b);
    logic [SumW-1:0] sum;
    sum = SumW'(a) + SumW'(b);
    if (sum > SumW'(CntMax)) return CntMax;
    return sum[CntWidth-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  state_t                st_q;
  logic [Length-1:0]     lfsr;
  logic [SeedCntW-1:0]   seed_cnt;
  logic [GoodW-1:0]      good_cnt;
  logic [BadW-1:0]       bad_cnt;

  // ---- stage p0: input conditioning and comparison against prediction ----
  logic [OutBits-1:0]    d_p0;
  logic [Length-1:0]     lfsr_nx_p0;
  logic [Length-1:0]     seed_nx_p0;
  logic [OutBits-1:0]    diff_p0;
  logic [PopW-1:0]       pop_p0;
  logic                  mis_p0;
  logic                  cnt_en_p0;
  logic                  loss_p0;

  assign d_p0       = data_in ^ {OutBits{data_inv}};
  assign lfsr_nx_p0 = lfsr_adv(lfsr);
  assign seed_nx_p0 = {d_p0, lfsr[Length-1:OutBits]};
  assign diff_p0    = d_p0 ^ lfsr_nx_p0[Length-1 -: OutBits];
  assign pop_p0     = popcount(diff_p0);
  assign mis_p0     = |diff_p0;
  assign cnt_en_p0  = start && valid && (st_q == ST_LOCKED);
  assign loss_p0    = cnt_en_p0 && mis_p0 && (bad_cnt == BadW'(LossWords - 1));

  assign state = st_q;

  // ---- stage p1: FSM, LFSR and counters ----
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      locked   <= 1'b0;
      err_word <= 1'b0;
      lfsr     <= '0;
      seed_cnt <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      err_bits <= '0;
      words    <= '0;
      loss_cnt <= '0;
    end else begin
      err_word <= 1'b0;
      if (!start) begin
        st_q   <= ST_IDLE;
        locked <= 1'b0;
      end else if (valid) begin
        case (st_q)
          // The word that wakes the checker is not used for seeding.
          ST_IDLE: begin
            st_q     <= ST_SEED;
            seed_cnt <= '0;
          end
          ST_SEED: begin
            lfsr <= seed_nx_p0;
            if (seed_cnt == SeedCntW'(SeedWords - 1)) begin
              seed_cnt <= '0;
              if (seed_nx_p0 != '0) begin
                st_q     <= ST_VERIFY;
                good_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + SeedCntW'(1);
            end
          end
          ST_VERIFY: begin
            lfsr <= lfsr_nx_p0;
            if (mis_p0) begin
              st_q     <= ST_SEED;
              seed_cnt <= '0;
            end else if (good_cnt == GoodW'(LockWords - 1)) begin
              st_q    <= ST_LOCKED;
              locked  <= 1'b1;
              bad_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GoodW'(1);
            end
          end
          ST_LOCKED: begin
            // Free-running: errored words never reseed the LFSR here.
            lfsr <= lfsr_nx_p0;
            if (mis_p0) begin
              err_word <= 1'b1;
              if (loss_p0) begin
                st_q     <= ST_SEED;
                locked   <= 1'b0;
                seed_cnt <= '0;
              end else begin
                bad_cnt <= bad_cnt + BadW'(1);
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: begin
            st_q   <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      // Clear wins over a same-cycle increment.
      if (clear_cnt) begin
        err_bits <= '0;
        words    <= '0;
        loss_cnt <= '0;
      end else if (cnt_en_p0) begin
        err_bits <= sat_add(err_bits, pop_p0);
        words    <= sat_add(words, PopW'(1));
        if (loss_p0) loss_cnt <= sat_inc8(loss_cnt);
      end
    end
  end

`ifdef PRBS_CHECKER_ERR_CAPTURE_EN
  logic cap_done;

  always_ff @(posedge clk) begin
    if (reset || clear_cnt) begin
      cap_done  <= 1'b0;
      err_mask  <= '0;
      err_index <= '0;
    end else if (cnt_en_p0 && mis_p0 && !cap_done) begin
      cap_done  <= 1'b1;
      err_mask  <= diff_p0;
      err_index <= words;
    end
  end
`else
  assign err_mask  = '0;
  assign err_index = '0;
`endif

endmodule
